reg_move_sequencer: RTL and testbench
=====================================

Name: reg_move_sequencer

Overview:
- Upstream control stage for the eight-register unit (A, B, C, D, M1, M2, X, Y).
- Accepts one decoded instruction byte per handshake and plays out a timed select/load strobe sequence.
- The strobes drive the register unit's sel*/ld* inputs, moving a byte between registers over the data bus, or loading a sign-extended immediate into A or B.
- Strobe timing models relay practice: source driven first, load pulsed, load released before source.

Parameters:
SETTLE_CYCLES, 1, cycles the bus source is driven before ld asserts; legal 1..15
HOLD_CYCLES, 1, cycles ld is held asserted; legal 1..15

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
instr  input  8  instruction byte
instr_valid  input  1  instr is valid
instr_ready  output  1  sequencer can accept instr this cycle
sel  output  8  one-hot bus-source select; bit order 0=A,1=B,2=C,3=D,4=M1,5=M2,6=X,7=Y
ld  output  8  one-hot register load, same bit order
imm_drive  output  1  sequencer drives imm_out onto data bus
imm_out  output  8  sign-extended immediate
busy  output  1  sequence in progress
done  output  1  one-cycle pulse, last cycle of a sequence
illegal  output  1  one-cycle pulse, unsupported opcode accepted

Behaviour:
- Reset, asynchronous on rst_n low: state IDLE; sel=0, ld=0, imm_drive=0, imm_out=0, busy=0, done=0, illegal=0.
- instr_ready=1 only in IDLE with rst_n high.
- Accept on rising edge with instr_valid && instr_ready. instr is not sampled otherwise.
- All outputs are registered; the first strobes appear the cycle after accept.
- Decode of instr[7:6]:
  - 00 MOV8: dst=instr[5:3], src=instr[2:0].
  - 01 SETAB: r=instr[5] (0=A, 1=B); imm=sign-extend(instr[4:0]), e.g. 0x1F -> 0xFF, 0x0F -> 0x0F.
  - 10, 11: illegal.
- Illegal: state ILL for exactly 1 cycle with illegal=1, no strobes, then IDLE. busy=1 in ILL.
- FSM: IDLE -> DRIVE (SETTLE_CYCLES) -> LOAD (HOLD_CYCLES) -> RELEASE (1 cycle) -> IDLE.
- DRIVE: the source is asserted, all ld=0.
  - Source is sel[src] for MOV8.
  - Source is imm_drive=1 with imm_out=imm for SETAB.
- LOAD: source held and ld[dst] asserted. dst is r for SETAB.
- RELEASE: source still held, ld=0, done=1.
- Next cycle: all strobes 0, instr_ready=1.
- busy=1 in every non-IDLE state.
- MOV8 with dst==src clears that register:
  - sel stays 0 throughout, so the undriven bus reads 0.
  - ld[dst] pulses per normal timing.
  - This is the only case where ld asserts without a driven source.
- imm_out holds its value through RELEASE and returns to 0 in IDLE.
- Occupancy: SETTLE+HOLD+1 cycles. With defaults, 3 cycles after accept, and a new instr is accepted on the 4th edge.
- A per-state down-counter, 4 bits, is loaded on state entry. The state advances when the counter reaches 0.
- Invariants:
  - At most one sel bit and one ld bit are set.
  - sel and imm_drive are never both set.
  - ld never rises in the same cycle the source rises.
  - ld falls at least 1 cycle before the source falls.
- instr_valid held high in IDLE: back-to-back instructions are accepted with no idle gap beyond the 1 IDLE cycle.
- Reset mid-sequence: all strobes drop immediately (asynchronous), no done pulse, the instruction is discarded, IDLE after deassertion.

Test Plan:
- Reset during LOAD of MOV8 C<-B (0x11) -> ld and sel go 0 combinationally with rst_n low; no done pulse; instr_ready=1 the first cycle after release.
- MOV8 D<-A (instr=0x18), defaults -> cycle1 sel=0x01, ld=0; cycle2 sel=0x01, ld=0x08; cycle3 sel=0x01, ld=0, done=1; cycle4 all 0, instr_ready=1.
- SETAB B=-1 (instr=0x7F) -> imm_drive=1, imm_out=0xFF for 3 cycles; ld=0x02 in cycle2 only. SETAB A=15 (0x4F) -> imm_out=0x0F, ld=0x01.
- MOV8 M1<-M1 (0x24) -> sel=0 throughout, ld=0x10 in cycle2, done in cycle3.
- instr=0x80 and 0xC5 -> illegal=1 for 1 cycle, sel=ld=0, no done, ready the next cycle.
- SETTLE_CYCLES=3, HOLD_CYCLES=2, MOV8 Y<-X (0x3E) -> sel=0x40 for 6 cycles, ld=0x80 in cycles 4-5, done in cycle 6. Then 0x3E and 0x07 back-to-back with valid held -> second accepted exactly 1 IDLE cycle after the first done.

Source files
------------

// File: rtl/reg_move_sequencer.sv
// Control sequencer for the eight-register unit: accepts one decoded instruction
// byte and plays out a drive -> load -> release strobe sequence on sel/ld.
module reg_move_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] instr,
  input  logic       instr_valid,
  output logic       instr_ready,
  output logic [7:0] sel,
  output logic [7:0] ld,
  output logic       imm_drive,
  output logic [7:0] imm_out,
  output logic       busy,
  output logic       done,
  output logic       illegal
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned REG_W = 8;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_LOAD,
    S_RELEASE,
    S_ILL
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [REG_W-1:0] r_sel;
  logic [REG_W-1:0] r_ld;
  logic [REG_W-1:0] r_dst;
  logic [REG_W-1:0] r_imm_out;
  logic             r_imm_drive;
  logic             r_busy;
  logic             r_done;
  logic             r_illegal;
  logic             r_ready;

  // Instruction decode
  logic [1:0]       w_op;
  logic [2:0]       w_dst_idx;
  logic [2:0]       w_src_idx;
  logic [REG_W-1:0] w_dst_oh;
  logic [REG_W-1:0] w_src_oh;
  logic [REG_W-1:0] w_imm;
  logic [REG_W-1:0] w_setab_dst;
  logic             w_accept;

  assign w_op        = instr[7:6];
  assign w_dst_idx   = instr[5:3];
  assign w_src_idx   = instr[2:0];
  assign w_dst_oh    = REG_W'(1) << w_dst_idx;
  // dst==src leaves the bus undriven so the destination loads zero
  assign w_src_oh    = (w_dst_idx == w_src_idx) ? '0 : (REG_W'(1) << w_src_idx);
  assign w_imm       = {{3{instr[4]}}, instr[4:0]};
  assign w_setab_dst = instr[5] ? 8'h02 : 8'h01;
  assign w_accept    = instr_valid && r_ready;

  // Sequencer FSM with registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_sel       <= '0;
      r_ld        <= '0;
      r_dst       <= '0;
      r_imm_out   <= '0;
      r_imm_drive <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_illegal   <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            case (w_op)
              2'b00: begin
                r_state <= S_DRIVE;
                r_cnt   <= SETTLE_LOAD;
                r_sel   <= w_src_oh;
                r_dst   <= w_dst_oh;
              end
              2'b01: begin
                r_state     <= S_DRIVE;
                r_cnt       <= SETTLE_LOAD;
                r_imm_drive <= 1'b1;
                r_imm_out   <= w_imm;
                r_dst       <= w_setab_dst;
              end
              default: begin
                r_state   <= S_ILL;
                r_illegal <= 1'b1;
              end
            endcase
          end
        end
        S_DRIVE: begin
          if (r_cnt == '0) begin
            r_state <= S_LOAD;
            r_cnt   <= HOLD_LOAD;
            r_ld    <= r_dst;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_LOAD: begin
          if (r_cnt == '0) begin
            r_state <= S_RELEASE;
            r_ld    <= '0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          // RELEASE and ILL both return to IDLE with every strobe dropped
          r_state     <= S_IDLE;
          r_sel       <= '0;
          r_ld        <= '0;
          r_imm_drive <= 1'b0;
          r_imm_out   <= '0;
          r_busy      <= 1'b0;
          r_ready     <= 1'b1;
        end
      endcase
    end
  end

  assign instr_ready = r_ready && rst_n;
  assign sel         = r_sel;
  assign ld          = r_ld;
  assign imm_drive   = r_imm_drive;
  assign imm_out     = r_imm_out;
  assign busy        = r_busy;
  assign done        = r_done;
  assign illegal     = r_illegal;

endmodule

// File: tb/tb_reg_move_sequencer.sv
// Directed table-driven bench for reg_move_sequencer: default timing instance
// and a SETTLE=3/HOLD=2 instance, plus a mid-sequence reset scenario.
module tb_reg_move_sequencer;

  typedef struct {
    logic        valid;
    logic [7:0]  instr;
    logic [28:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] instr1 = 8'h00, instr2 = 8'h00;
  logic       valid1 = 1'b0, valid2 = 1'b0;

  logic       rdy1, immd1, busy1, done1, ill1;
  logic [7:0] sel1, ld1, immo1;
  logic       rdy2, immd2, busy2, done2, ill2;
  logic [7:0] sel2, ld2, immo2;
  logic [28:0] out1, out2;

  int checks = 0;
  int failures = 0;

  vec_t t1[$];
  vec_t t2[$];

  always #5 clk = ~clk;

  reg_move_sequencer dut1 (
    .clk(clk), .rst_n(rst_n), .instr(instr1), .instr_valid(valid1),
    .instr_ready(rdy1), .sel(sel1), .ld(ld1), .imm_drive(immd1),
    .imm_out(immo1), .busy(busy1), .done(done1), .illegal(ill1)
  );

  reg_move_sequencer #(.SETTLE_CYCLES(3), .HOLD_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .instr(instr2), .instr_valid(valid2),
    .instr_ready(rdy2), .sel(sel2), .ld(ld2), .imm_drive(immd2),
    .imm_out(immo2), .busy(busy2), .done(done2), .illegal(ill2)
  );

  // Packed view: {sel, ld, imm_drive, imm_out, busy, done, illegal, ready}
  assign out1 = {sel1, ld1, immd1, immo1, busy1, done1, ill1, rdy1};
  assign out2 = {sel2, ld2, immd2, immo2, busy2, done2, ill2, rdy2};

  function automatic logic [28:0] pk(input logic [7:0] s, input logic [7:0] l,
                                     input logic d, input logic [7:0] im,
                                     input logic b, input logic dn,
                                     input logic il, input logic r);
    return {s, l, d, im, b, dn, il, r};
  endfunction

  function automatic vec_t mk(input logic v, input logic [7:0] ins, input logic [28:0] e);
    vec_t x;
    x.valid = v;
    x.instr = ins;
    x.exp   = e;
    return x;
  endfunction

  task automatic check(input string name, input logic [28:0] act, input logic [28:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got sel=%02h ld=%02h immd=%0b imm=%02h busy=%0b done=%0b ill=%0b rdy=%0b, want sel=%02h ld=%02h immd=%0b imm=%02h busy=%0b done=%0b ill=%0b rdy=%0b",
               name, act[28:21], act[20:13], act[12], act[11:4], act[3], act[2], act[1], act[0],
               exp[28:21], exp[20:13], exp[12], exp[11:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Drive one row's inputs, clock once, and compare the registered outputs
  task automatic run_row(input int d, input int idx, input vec_t v);
    if (d == 1) begin valid1 = v.valid; instr1 = v.instr; end
    else        begin valid2 = v.valid; instr2 = v.instr; end
    @(posedge clk);
    #1;
    check($sformatf("dut%0d_row%0d", d, idx), (d == 1) ? out1 : out2, v.exp);
  endtask

  initial begin
    logic [28:0] idle_w;
    idle_w = pk(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Default timing: idle with valid low, MOV8 D<-A, SETAB B=-1, SETAB A=15,
    // MOV8 M1<-M1, two illegal opcodes, then back-to-back MOV8 with valid held
    t1.push_back(mk(1'b0, 8'h18, idle_w));
    t1.push_back(mk(1'b1, 8'h18, pk(8'h01, 8'h00, 0, 8'h00, 1, 0, 0, 0)));
    t1.push_back(mk(1'b1, 8'hC5, pk(8'h01, 8'h08, 0, 8'h00, 1, 0, 0, 0)));
    t1.push_back(mk(1'b0, 8'h00, pk(8'h01, 8'h00, 0, 8'h00, 1, 1, 0, 0)));
    t1.push_back(mk(1'b0, 8'h00, idle_w));
    t1.push_back(mk(1'b1, 8'h7F, pk(8'h00, 8'h00, 1, 8'hFF, 1, 0, 0, 0)));
    t1.push_back(mk(1'b0, 8'h00, pk(8'h00, 8'h02, 1, 8'hFF, 1, 0, 0, 0)));
    t1.push_back(mk(1'b0, 8'h00, pk(8'h00, 8'h00, 1, 8'hFF, 1, 1, 0, 0)));
    t1.push_back(mk(1'b0, 8'h00, idle_w));
    t1.push_back(mk(1'b1, 8'h4F, pk(8'h00, 8'h00, 1, 8'h0F, 1, 0, 0, 0)));
    t1.push_back(mk(1'b0, 8'h00, pk(8'h00, 8'h01, 1, 8'h0F, 1, 0, 0, 0)));
    t1.push_back(mk(1'b0, 8'h00, pk(8'h00, 8'h00, 1, 8'h0F, 1, 1, 0, 0)));
    t1.push_back(mk(1'b0, 8'h00, idle_w));
    t1.push_back(mk(1'b1, 8'h24, pk(8'h00, 8'h00, 0, 8'h00, 1, 0, 0, 0)));
    t1.push_back(mk(1'b0, 8'h00, pk(8'h00, 8'h10, 0, 8'h00, 1, 0, 0, 0)));
    t1.push_back(mk(1'b0, 8'h00, pk(8'h00, 8'h00, 0, 8'h00, 1, 1, 0, 0)));
    t1.push_back(mk(1'b0, 8'h00, idle_w));
    t1.push_back(mk(1'b1, 8'h80, pk(8'h00, 8'h00, 0, 8'h00, 1, 0, 1, 0)));
    t1.push_back(mk(1'b0, 8'h00, idle_w));
    t1.push_back(mk(1'b1, 8'hC5, pk(8'h00, 8'h00, 0, 8'h00, 1, 0, 1, 0)));
    t1.push_back(mk(1'b0, 8'h00, idle_w));
    t1.push_back(mk(1'b1, 8'h18, pk(8'h01, 8'h00, 0, 8'h00, 1, 0, 0, 0)));
    t1.push_back(mk(1'b1, 8'h18, pk(8'h01, 8'h08, 0, 8'h00, 1, 0, 0, 0)));
    t1.push_back(mk(1'b1, 8'h18, pk(8'h01, 8'h00, 0, 8'h00, 1, 1, 0, 0)));
    t1.push_back(mk(1'b1, 8'h18, idle_w));
    t1.push_back(mk(1'b1, 8'h18, pk(8'h01, 8'h00, 0, 8'h00, 1, 0, 0, 0)));
    t1.push_back(mk(1'b0, 8'h00, pk(8'h01, 8'h08, 0, 8'h00, 1, 0, 0, 0)));
    t1.push_back(mk(1'b0, 8'h00, pk(8'h01, 8'h00, 0, 8'h00, 1, 1, 0, 0)));
    t1.push_back(mk(1'b0, 8'h00, idle_w));

    // SETTLE=3, HOLD=2: MOV8 Y<-X then MOV8 A<-Y with valid held throughout
    t2.push_back(mk(1'b1, 8'h3E, pk(8'h40, 8'h00, 0, 8'h00, 1, 0, 0, 0)));
    t2.push_back(mk(1'b1, 8'h07, pk(8'h40, 8'h00, 0, 8'h00, 1, 0, 0, 0)));
    t2.push_back(mk(1'b1, 8'h07, pk(8'h40, 8'h00, 0, 8'h00, 1, 0, 0, 0)));
    t2.push_back(mk(1'b1, 8'h07, pk(8'h40, 8'h80, 0, 8'h00, 1, 0, 0, 0)));
    t2.push_back(mk(1'b1, 8'h07, pk(8'h40, 8'h80, 0, 8'h00, 1, 0, 0, 0)));
    t2.push_back(mk(1'b1, 8'h07, pk(8'h40, 8'h00, 0, 8'h00, 1, 1, 0, 0)));
    t2.push_back(mk(1'b1, 8'h07, idle_w));
    t2.push_back(mk(1'b1, 8'h07, pk(8'h80, 8'h00, 0, 8'h00, 1, 0, 0, 0)));
    t2.push_back(mk(1'b0, 8'h00, pk(8'h80, 8'h00, 0, 8'h00, 1, 0, 0, 0)));
    t2.push_back(mk(1'b0, 8'h00, pk(8'h80, 8'h00, 0, 8'h00, 1, 0, 0, 0)));
    t2.push_back(mk(1'b0, 8'h00, pk(8'h80, 8'h01, 0, 8'h00, 1, 0, 0, 0)));
    t2.push_back(mk(1'b0, 8'h00, pk(8'h80, 8'h01, 0, 8'h00, 1, 0, 0, 0)));
    t2.push_back(mk(1'b0, 8'h00, pk(8'h80, 8'h00, 0, 8'h00, 1, 1, 0, 0)));
    t2.push_back(mk(1'b0, 8'h00, idle_w));

    // Reset state while rst_n is low: everything zero, including ready
    repeat (2) @(posedge clk);
    #1;
    check("reset_dut1", out1, 29'd0);
    check("reset_dut2", out2, 29'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_idle", out1, idle_w);

    foreach (t1[i]) run_row(1, i, t1[i]);
    foreach (t2[i]) run_row(2, i, t2[i]);

    // Reset during LOAD of MOV8 C<-B: strobes drop asynchronously, no done
    @(negedge clk);
    valid1 = 1'b1;
    instr1 = 8'h11;
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    check("rst_seq_drive", out1, pk(8'h02, 8'h00, 0, 8'h00, 1, 0, 0, 0));
    @(posedge clk);
    #1;
    check("rst_seq_load", out1, pk(8'h02, 8'h04, 0, 8'h00, 1, 0, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_drop", out1, 29'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready_after", out1, idle_w);
    @(posedge clk);
    #1;
    check("rst_no_done", out1, idle_w);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
